// File: rtl/apb_mem_slave_ws.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : apb_mem_slave_ws                                             |
// | Description : APB3 slave bridging to a synchronous single-port memory,     |
// |               with per-transfer wait states, range-error response and      |
// |               abort on psel drop.                                          |
// | Revision    : 1.0 - initial parametrised release                           |
// +----------------------------------------------------------------------------+
module apb_mem_slave_ws #(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 8,
  parameter int MEM_DEPTH = 256,
  parameter int WAIT_W    = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [WAIT_W-1:0] pwait,
  output logic              pready,
  output logic [DATA_W-1:0] prdata,
  output logic              pslverr,
  output logic              mem_wren,
  output logic              mem_rden,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One extra bit so a depth of exactly 2**ADDR_W is representable.
  localparam logic [ADDR_W:0] c_mem_depth = (ADDR_W+1)'(MEM_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_dir;
  logic                w_dir_nxt;
  logic [WAIT_W-1:0]   r_cnt;
  logic [WAIT_W-1:0]   w_cnt_nxt;
  logic                r_rd_resp;
  logic                w_rd_resp_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [DATA_W-1:0]   w_wdata_nxt;
  logic                w_pready_nxt;
  logic                w_pslverr_nxt;
  logic                w_wren_nxt;
  logic                w_rden_nxt;
  logic                w_setup;
  logic                w_addr_err;

  assign w_setup    = psel && !penable;
  assign w_addr_err = ({1'b0, paddr} >= c_mem_depth);

  // Next-state and next-output logic; every output is registered from these.
  always_comb begin
    w_state_nxt   = r_state;
    w_dir_nxt     = r_dir;
    w_cnt_nxt     = r_cnt;
    w_addr_nxt    = mem_addr;
    w_wdata_nxt   = mem_wdata;
    w_pready_nxt  = 1'b0;
    w_pslverr_nxt = 1'b0;
    w_wren_nxt    = 1'b0;
    w_rden_nxt    = 1'b0;
    w_rd_resp_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_setup) begin
          w_addr_nxt  = paddr;
          w_wdata_nxt = pwdata;
          w_dir_nxt   = pwrite;
          w_cnt_nxt   = pwait;
          if (w_addr_err) begin
            // Out-of-range: answer with an error, never touch the memory.
            w_state_nxt   = ST_RESP;
            w_pready_nxt  = 1'b1;
            w_pslverr_nxt = 1'b1;
          end else if (pwait != '0) begin
            w_state_nxt = ST_WAIT;
          end else begin
            w_state_nxt = ST_ACCESS;
            w_wren_nxt  = pwrite;
            w_rden_nxt  = !pwrite;
          end
        end
      end
      ST_WAIT: begin
        if (!psel) begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == WAIT_W'(1)) begin
          w_state_nxt = ST_ACCESS;
          w_cnt_nxt   = '0;
          w_wren_nxt  = r_dir;
          w_rden_nxt  = !r_dir;
        end else begin
          w_cnt_nxt = r_cnt - WAIT_W'(1);
        end
      end
      ST_ACCESS: begin
        // The strobe is already out; an abort only suppresses the response.
        if (!psel) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt   = ST_RESP;
          w_pready_nxt  = 1'b1;
          w_rd_resp_nxt = !r_dir;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // State, counter and registered bus outputs with asynchronous clear.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state   <= ST_IDLE;
      r_dir     <= 1'b0;
      r_cnt     <= '0;
      r_rd_resp <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      pready    <= 1'b0;
      pslverr   <= 1'b0;
      mem_wren  <= 1'b0;
      mem_rden  <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_dir     <= w_dir_nxt;
      r_cnt     <= w_cnt_nxt;
      r_rd_resp <= w_rd_resp_nxt;
      mem_addr  <= w_addr_nxt;
      mem_wdata <= w_wdata_nxt;
      pready    <= w_pready_nxt;
      pslverr   <= w_pslverr_nxt;
      mem_wren  <= w_wren_nxt;
      mem_rden  <= w_rden_nxt;
    end
  end

  // Memory read data only becomes valid in the response cycle, so it is
  // steered onto prdata by a registered read-response flag; zero otherwise.
  assign prdata = r_rd_resp ? mem_rdata : '0;

endmodule
`default_nettype wire
